unified_mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory of the multi-cycle ARM core between two requesters:

---
 rtl/unified_mem_arbiter_pkg.sv | 13 +
 rtl/unified_mem_arbiter_rr_pick2.sv | 18 +
 rtl/unified_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states and requester ids.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_rr_pick2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to the port rr_ptr names.
module rr_pick2
  import unified_mem_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic rr_ptr_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic favour_ldr;

  assign favour_ldr = (rr_ptr_i == PORT_LDR);
  assign gnt0_o     = req0_i & (~req1_i | ~favour_ldr);
  assign gnt1_o     = req1_i & (~req0_i |  favour_ldr);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises CPU (port 0) and loader/DMA (port 1) accesses onto one memory, one transaction at a time.
// Grant in IDLE, MEM_LAT access cycles from latched request, one RESP cycle with the completion pulse.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pick0, pick1;

  rr_pick2 u_pick (
    .req0_i   (req0),
    .req1_i   (req1),
    .rr_ptr_i (rr_q),
    .gnt0_o   (pick0),
    .gnt1_o   (pick1)
  );

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata     = '0;
    busy      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick0 || pick1) begin
          gnt0    = pick0;
          gnt1    = pick1;
          owner_d = pick1 ? PORT_LDR : PORT_CPU;
          we_d    = pick1 ? we1 : we0;
          addr_d  = pick1 ? addr1 : addr0;
          wdata_d = pick1 ? wdata1 : wdata0;
          cnt_d   = CW'(MEM_LAT - 1);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (cnt_q == '0) begin
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        busy    = 1'b1;
        rvalid0 = (owner_q == PORT_CPU);
        rvalid1 = (owner_q == PORT_LDR);
        rdata   = rdata_q;
        rr_d    = ~owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are forced quiet for the whole reset cycle, including any in-flight access.
    if (RESET) begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
      rdata     = '0;
      busy      = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      rr_q    <= PORT_CPU;
      owner_q <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: one instance with MEM_LAT=1 (a_*) and one with MEM_LAT=3 (b_*).
module tb_unified_mem_arbiter;

  localparam int LB = 3;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        a_req0 = 0, a_req1 = 0, a_we0 = 0, a_we1 = 0;
  logic [31:0] a_addr0 = 0, a_addr1 = 0, a_wdata0 = 0, a_wdata1 = 0;
  logic        a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_busy, a_mem_en, a_mem_we;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_req0 = 0, b_req1 = 0, b_we0 = 0, b_we1 = 0;
  logic [31:0] b_addr0 = 0, b_addr1 = 0, b_wdata0 = 0, b_wdata1 = 0;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy, b_mem_en, b_mem_we;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [31:0] a_mem [0:15];
  logic [31:0] b_mem [0:15];
  logic        a_ld = 0, b_ld = 0;
  logic [3:0]  a_ld_idx = 0, b_ld_idx = 0;
  logic [31:0] a_ld_val = 0, b_ld_val = 0;

  assign a_mem_rdata = a_mem[a_mem_addr[5:2]];
  assign b_mem_rdata = b_mem[b_mem_addr[5:2]];

  always @(posedge clk) begin
    if (a_ld) a_mem[a_ld_idx] <= a_ld_val;
    else if (a_mem_en && a_mem_we) a_mem[a_mem_addr[5:2]] <= a_mem_wdata;
    if (b_ld) b_mem[b_ld_idx] <= b_ld_val;
    else if (b_mem_en && b_mem_we) b_mem[b_mem_addr[5:2]] <= b_mem_wdata;
  end

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .RESET(RESET), .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
    .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1), .rdata(a_rdata),
    .busy(a_busy), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LB)) dut_b (
    .clk(clk), .RESET(RESET), .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1), .rdata(b_rdata),
    .busy(b_busy), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

  // Each cycle: advance past the edge, drive inputs, then #1 later sample outputs.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input int idx, input logic [31:0] v);
    next_cycle();
    a_ld = 1; a_ld_idx = 4'(idx); a_ld_val = v;
    next_cycle();
    a_ld = 0;
  endtask

  task automatic load_b(input int idx, input logic [31:0] v);
    next_cycle();
    b_ld = 1; b_ld_idx = 4'(idx); b_ld_val = v;
    next_cycle();
    b_ld = 0;
  endtask

  task automatic reset_pulse();
    next_cycle();
    RESET = 1;
    a_req0 = 0; a_req1 = 0; b_req0 = 0; b_req1 = 0;
    next_cycle();
    RESET = 0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 3) begin
        RESET = 0;
        a_req0 = 0; a_req1 = 0; b_req0 = 0; b_req1 = 0;
      end else begin
        a_req0 = 1; a_req1 = 1; b_req0 = 1; b_req1 = 1;
      end
      #1;
      checks++;
      if ({a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_busy, a_mem_en, a_mem_we} !== 7'b0 ||
          {a_rdata, a_mem_addr, a_mem_wdata} !== 96'b0) begin
        failures++;
        $display("FAIL reset_a cycle %0d: ctrl=%b data=%h required all zero", k,
                 {a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_busy, a_mem_en, a_mem_we},
                 {a_rdata, a_mem_addr, a_mem_wdata});
      end
      checks++;
      if ({b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy, b_mem_en, b_mem_we} !== 7'b0 ||
          {b_rdata, b_mem_addr, b_mem_wdata} !== 96'b0) begin
        failures++;
        $display("FAIL reset_b cycle %0d: ctrl=%b data=%h required all zero", k,
                 {b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy, b_mem_en, b_mem_we},
                 {b_rdata, b_mem_addr, b_mem_wdata});
      end
    end
  endtask

  task automatic test_single_read();
    load_a(4, 32'hDEAD_BEEF);
    next_cycle();
    a_req0 = 1; a_we0 = 0; a_addr0 = 32'h10;
    #1;
    checks++;
    if ({a_gnt0, a_gnt1} !== 2'b10) begin
      failures++; $display("FAIL read_gnt: {gnt0,gnt1}=%b required 10", {a_gnt0, a_gnt1});
    end
    next_cycle();
    a_req0 = 0;
    #1;
    checks++;
    if ({a_mem_en, a_mem_we, a_mem_addr} !== {2'b10, 32'h10}) begin
      failures++;
      $display("FAIL read_access: en=%b we=%b addr=%h required 1 0 10", a_mem_en, a_mem_we, a_mem_addr);
    end
    next_cycle();
    #1;
    checks++;
    if ({a_rvalid0, a_rvalid1, a_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL read_resp: rvalid0=%b rvalid1=%b rdata=%h required 1 0 deadbeef",
               a_rvalid0, a_rvalid1, a_rdata);
    end
    next_cycle();
    #1;
    checks++;
    if ({a_busy, a_rvalid0} !== 2'b00) begin
      failures++; $display("FAIL read_idle: busy=%b rvalid0=%b required 0 0", a_busy, a_rvalid0);
    end
  endtask

  task automatic test_tie();
    int gq[$]; int gc[$]; int vq[$]; int vc[$];
    logic [31:0] dq[$];
    logic both = 0;
    load_a(12, 32'h1111_0000);
    load_a(13, 32'h2222_0001);
    reset_pulse();
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      if (k == 0) begin
        a_req0 = 1; a_req1 = 1; a_we0 = 0; a_we1 = 0; a_addr0 = 32'h30; a_addr1 = 32'h34;
      end
      if (gq.size() == 4) begin a_req0 = 0; a_req1 = 0; end
      #1;
      if (a_gnt0 && a_gnt1) both = 1;
      if (a_gnt0) begin gq.push_back(0); gc.push_back(k); end
      if (a_gnt1) begin gq.push_back(1); gc.push_back(k); end
      if (a_rvalid0) begin vq.push_back(0); vc.push_back(k); dq.push_back(a_rdata); end
      if (a_rvalid1) begin vq.push_back(1); vc.push_back(k); dq.push_back(a_rdata); end
    end
    checks++;
    if (both !== 1'b0) begin failures++; $display("FAIL tie_double_gnt: seen=%b required 0", both); end
    checks++;
    if (gq.size() != 4 || vq.size() != 4) begin
      failures++; $display("FAIL tie_count: grants=%0d rvalids=%0d required 4 4", gq.size(), vq.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size() && i < vq.size()) begin
        checks++;
        if (gq[i] != i % 2 || vq[i] != i % 2 || gc[i] != 3 * i || vc[i] != 3 * i + 2 ||
            dq[i] !== ((i % 2) ? 32'h2222_0001 : 32'h1111_0000)) begin
          failures++;
          $display("FAIL tie_txn%0d: gnt port %0d @%0d rvalid port %0d @%0d data %h required port %0d @%0d/@%0d",
                   i, gq[i], gc[i], vq[i], vc[i], dq[i], i % 2, 3 * i, 3 * i + 2);
        end
      end
    end
  endtask

  task automatic test_write_read();
    int we_cnt = 0;
    int rv_at = -1;
    logic [31:0] rv_data = 32'hFFFF_FFFF;
    next_cycle();
    b_req1 = 1; b_we1 = 1; b_addr1 = 32'h20; b_wdata1 = 32'h44;
    #1;
    checks++;
    if ({b_gnt0, b_gnt1} !== 2'b01) begin
      failures++; $display("FAIL write_gnt: {gnt0,gnt1}=%b required 01", {b_gnt0, b_gnt1});
    end
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      b_req1 = 0;
      #1;
      if (b_mem_we && b_mem_en && b_mem_addr == 32'h20 && b_mem_wdata == 32'h44) we_cnt++;
      if (b_rvalid1) begin rv_at = k; rv_data = b_rdata; end
    end
    checks++;
    if (we_cnt != 3 || rv_at != 4 || rv_data !== 32'h0) begin
      failures++;
      $display("FAIL write_seq: we_cycles=%0d rvalid1_at=%0d rdata=%h required 3 4 0", we_cnt, rv_at, rv_data);
    end
    rv_at = -1;
    next_cycle();
    b_req0 = 1; b_we0 = 0; b_addr0 = 32'h20;
    #1;
    checks++;
    if (b_gnt0 !== 1'b1) begin failures++; $display("FAIL readback_gnt: gnt0=%b required 1", b_gnt0); end
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      b_req0 = 0;
      #1;
      if (b_rvalid0) begin rv_at = k; rv_data = b_rdata; end
    end
    checks++;
    if (rv_at != 4 || rv_data !== 32'h44) begin
      failures++; $display("FAIL readback: rvalid0_at=%0d rdata=%h required 4 44", rv_at, rv_data);
    end
  endtask

  task automatic test_reset_mid();
    logic rv_seen = 0;
    next_cycle();
    b_req0 = 1; b_we0 = 0; b_addr0 = 32'h0;
    #1;
    checks++;
    if (b_gnt0 !== 1'b1) begin failures++; $display("FAIL midrst_gnt: gnt0=%b required 1", b_gnt0); end
    next_cycle();
    b_req0 = 0;
    #1;
    checks++;
    if (b_mem_en !== 1'b1) begin failures++; $display("FAIL midrst_access1: mem_en=%b required 1", b_mem_en); end
    next_cycle();
    RESET = 1;
    #1;
    checks++;
    if ({b_mem_en, b_busy} !== 2'b00) begin
      failures++; $display("FAIL midrst_during: mem_en=%b busy=%b required 0 0", b_mem_en, b_busy);
    end
    next_cycle();
    RESET = 0;
    #1;
    checks++;
    if ({b_mem_en, b_busy, b_rvalid0, b_rvalid1} !== 4'b0) begin
      failures++; $display("FAIL midrst_after: mem_en=%b busy=%b rvalid=%b%b required 0000",
                           b_mem_en, b_busy, b_rvalid0, b_rvalid1);
    end
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      #1;
      if (b_rvalid0 || b_rvalid1) rv_seen = 1;
    end
    checks++;
    if (rv_seen !== 1'b0) begin failures++; $display("FAIL midrst_rvalid: seen=%b required 0", rv_seen); end
    next_cycle();
    b_req0 = 1; b_req1 = 1; b_we0 = 0; b_we1 = 0; b_addr0 = 32'h4; b_addr1 = 32'h8;
    #1;
    checks++;
    if ({b_gnt0, b_gnt1} !== 2'b10) begin
      failures++; $display("FAIL midrst_tie: {gnt0,gnt1}=%b required 10", {b_gnt0, b_gnt1});
    end
    next_cycle();
    b_req0 = 0; b_req1 = 0;
    repeat (5) next_cycle();
  endtask

  task automatic test_drop();
    int g0 = 0, en_cnt = 0, bad = 0, rv0 = 0;
    next_cycle();
    b_req1 = 1; b_we1 = 0; b_addr1 = 32'h3C;
    #1;
    checks++;
    if (b_gnt1 !== 1'b1) begin failures++; $display("FAIL drop_gnt1: gnt1=%b required 1", b_gnt1); end
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      b_req1 = 0;
      b_req0 = (k <= 3); b_we0 = 1; b_addr0 = 32'h08; b_wdata0 = 32'h55;
      #1;
      if (b_gnt0) g0++;
      if (b_mem_en) en_cnt++;
      if (b_mem_en && b_mem_addr == 32'h08) bad++;
      if (b_rvalid0) rv0++;
    end
    checks++;
    if (g0 != 0 || en_cnt != LB || bad != 0 || rv0 != 0) begin
      failures++;
      $display("FAIL drop: gnt0=%0d mem_en_cycles=%0d port0_accesses=%0d rvalid0=%0d required 0 %0d 0 0",
               g0, en_cnt, bad, rv0, LB);
    end
  endtask

  typedef struct {
    int          cyc;
    int          owner;
    logic [31:0] data;
  } exp_t;

  task automatic test_random();
    localparam int N = 300;
    logic [31:0] ref_mem [16];
    exp_t        eq[$];
    exp_t        e;
    logic        p_act [2];
    logic        p_we  [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd  [2];
    int          idle_at = 0;
    int          rr_m = 0;
    int          w;
    logic [1:0]  exp_g, exp_rv;
    logic [31:0] exp_d;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      load_b(i, ref_mem[i]);
    end
    for (int p = 0; p < 2; p++) begin p_act[p] = 0; p_we[p] = 0; p_addr[p] = 0; p_wd[p] = 0; end
    reset_pulse();
    for (int c = 0; c < N; c++) begin
      next_cycle();
      for (int p = 0; p < 2; p++) begin
        if (c >= N - 12) p_act[p] = 0;
        else if (p_act[p]) begin
          if ($urandom_range(9) == 0) p_act[p] = 0;
        end else if ($urandom_range(2) == 0) begin
          p_act[p] = 1; p_we[p] = 1'($urandom_range(1));
          p_addr[p] = 32'($urandom_range(15)) << 2; p_wd[p] = $urandom;
        end
      end
      b_req0 = p_act[0]; b_we0 = p_we[0]; b_addr0 = p_addr[0]; b_wdata0 = p_wd[0];
      b_req1 = p_act[1]; b_we1 = p_we[1]; b_addr1 = p_addr[1]; b_wdata1 = p_wd[1];
      #1;
      w = -1;
      if (c >= idle_at) begin
        if (p_act[0] && p_act[1]) w = rr_m;
        else if (p_act[0]) w = 0;
        else if (p_act[1]) w = 1;
      end
      exp_g = 2'b00;
      if (w >= 0) exp_g[w] = 1'b1;
      exp_rv = 2'b00; exp_d = 32'h0;
      if (eq.size() > 0 && eq[0].cyc == c) begin
        exp_rv[eq[0].owner] = 1'b1; exp_d = eq[0].data;
        void'(eq.pop_front());
      end
      checks++;
      if ({b_gnt1, b_gnt0} !== exp_g) begin
        failures++; $display("FAIL rand_gnt c=%0d: {gnt1,gnt0}=%b required %b", c, {b_gnt1, b_gnt0}, exp_g);
      end
      checks++;
      if ({b_busy, b_mem_en} !== {c < idle_at, c < idle_at - 1}) begin
        failures++; $display("FAIL rand_busy c=%0d: busy=%b mem_en=%b required %b %b",
                             c, b_busy, b_mem_en, c < idle_at, c < idle_at - 1);
      end
      checks++;
      if ({b_rvalid1, b_rvalid0} !== exp_rv) begin
        failures++; $display("FAIL rand_rvalid c=%0d: {rvalid1,rvalid0}=%b required %b", c,
                             {b_rvalid1, b_rvalid0}, exp_rv);
      end
      if (exp_rv != 2'b00) begin
        checks++;
        if (b_rdata !== exp_d) begin
          failures++; $display("FAIL rand_rdata c=%0d: rdata=%h required %h", c, b_rdata, exp_d);
        end
      end
      if (w >= 0) begin
        e.cyc = c + LB + 1; e.owner = w;
        e.data = p_we[w] ? 32'h0 : ref_mem[p_addr[w][5:2]];
        eq.push_back(e);
        if (p_we[w]) ref_mem[p_addr[w][5:2]] = p_wd[w];
        rr_m = 1 - w;
        idle_at = c + LB + 2;
        p_act[w] = 0;
      end
    end
    checks++;
    if (eq.size() != 0) begin
      failures++; $display("FAIL rand_drain: outstanding=%0d required 0", eq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_write_read();
    test_reset_mid();
    test_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
